// File: rtl/palindrome_tx.sv
// Palindromic bit-stream transmitter: serializes a W-bit word MSB-first, then mirrors it back.
// Odd mode drops the duplicated centre bit, giving 2W-1 beats instead of 2W.
module palindrome_tx #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     data_i,
  input  logic             odd_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] frames_o
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    data_q;
  logic            odd_q;
  logic            ready_q;
  logic            bit_q;
  logic            bit_valid_q;
  logic            sof_q;
  logic            eof_q;
  logic            busy_q;
  logic [CNT_W-1:0] frames_q;

  logic [IW-1:0]   idx_dec_d;
  logic [IW-1:0]   idx_inc_d;
  logic [IW-1:0]   rev_start_d;

  // Candidate indices for the beat that follows the one being presented
  always_comb begin
    idx_dec_d   = idx_q - IW'(1);
    idx_inc_d   = idx_q + IW'(1);
    rev_start_d = odd_q ? IW'(1) : IW'(0);
  end

  // Outputs are loaded with the beat to be presented next, so nothing is combinational from bit_ready_i
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      odd_q       <= 1'b0;
      ready_q     <= 1'b1;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      frames_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            state_q     <= FWD;
            data_q      <= data_i;
            odd_q       <= odd_i;
            idx_q       <= IDX_TOP;
            bit_q       <= data_i[W-1];
            bit_valid_q <= 1'b1;
            sof_q       <= 1'b1;
            eof_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        FWD: begin
          if (bit_ready_i) begin
            sof_q <= 1'b0;
            if (idx_q != IW'(0)) begin
              idx_q <= idx_dec_d;
              bit_q <= data_q[idx_dec_d];
            end else begin
              // W=2 odd lands straight on the last beat, so eof may assert here
              state_q <= REV;
              idx_q   <= rev_start_d;
              bit_q   <= data_q[rev_start_d];
              eof_q   <= (rev_start_d == IDX_TOP);
            end
          end
        end
        REV: begin
          if (bit_ready_i) begin
            if (idx_q == IDX_TOP) begin
              state_q     <= IDLE;
              bit_q       <= 1'b0;
              bit_valid_q <= 1'b0;
              eof_q       <= 1'b0;
              ready_q     <= 1'b1;
              busy_q      <= 1'b0;
              frames_q    <= frames_q + CNT_W'(1);
            end else begin
              idx_q <= idx_inc_d;
              bit_q <= data_q[idx_inc_d];
              eof_q <= (idx_inc_d == IDX_TOP);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign busy_o      = busy_q;
  assign frames_o    = frames_q;

endmodule

// File: tb/tb_palindrome_tx.sv
// Scoreboard bench for palindrome_tx: W=8 instance for frames, stalls and reset; W=2/CNT_W=4 for short frames and wrap.
module tb_palindrome_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  data_a;
  logic        odd_a, valid_a, ready_a, bit_a, bv_a, br_a, sof_a, eof_a, busy_a;
  logic [15:0] frames_a;
  logic [1:0]  data_b;
  logic        odd_b, valid_b, ready_b, bit_b, bv_b, br_b, sof_b, eof_b, busy_b;
  logic [3:0]  frames_b;

  palindrome_tx #(.W(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .data_i(data_a), .odd_i(odd_a), .valid_i(valid_a),
    .ready_o(ready_a), .bit_o(bit_a), .bit_valid_o(bv_a), .bit_ready_i(br_a),
    .sof_o(sof_a), .eof_o(eof_a), .busy_o(busy_a), .frames_o(frames_a)
  );

  palindrome_tx #(.W(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .data_i(data_b), .odd_i(odd_b), .valid_i(valid_b),
    .ready_o(ready_b), .bit_o(bit_b), .bit_valid_o(bv_b), .bit_ready_i(br_b),
    .sof_o(sof_b), .eof_o(eof_b), .busy_o(busy_b), .frames_o(frames_b)
  );

  typedef struct {
    logic b;
    logic sof;
    logic eof;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    exp_fa   = 0;
  int    exp_fb   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_bv(input bit sel);    return sel ? bv_b    : bv_a;    endfunction
  function automatic logic o_bit(input bit sel);   return sel ? bit_b   : bit_a;   endfunction
  function automatic logic o_sof(input bit sel);   return sel ? sof_b   : sof_a;   endfunction
  function automatic logic o_eof(input bit sel);   return sel ? eof_b   : eof_a;   endfunction
  function automatic logic o_ready(input bit sel); return sel ? ready_b : ready_a; endfunction
  function automatic logic o_busy(input bit sel);  return sel ? busy_b  : busy_a;  endfunction
  function automatic logic [31:0] o_frames(input bit sel);
    return sel ? 32'(frames_b) : 32'(frames_a);
  endfunction

  // Expected beats: forward MSB-first, then mirrored half (centre bit skipped in odd mode)
  task automatic push_frame(input logic [31:0] d, input bit odd, input int w);
    for (int i = w - 1; i >= 0; i--)
      exp_q.push_back(beat_t'{b: d[i], sof: (i == w - 1), eof: 1'b0});
    for (int i = (odd ? 1 : 0); i < w; i++)
      exp_q.push_back(beat_t'{b: d[i], sof: 1'b0, eof: (i == w - 1)});
  endtask

  task automatic send(input bit sel, input logic [31:0] d, input bit odd);
    @(negedge clk);
    check("ready_before_send", 32'(o_ready(sel)), 32'd1);
    if (sel) begin
      data_b = d[1:0]; odd_b = odd; valid_b = 1'b1;
    end else begin
      data_a = d[7:0]; odd_a = odd; valid_a = 1'b1;
    end
    push_frame(d, odd, sel ? 2 : 8);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    // Captured word must be immune to later upstream changes
    data_a = ~d[7:0]; odd_a = ~odd;
    data_b = ~d[1:0]; odd_b = ~odd;
    check("latency1_bv", 32'(o_bv(sel)), 32'd1);
    check("latency1_sof", 32'(o_sof(sel)), 32'd1);
    check("ready_low_busy", 32'(o_ready(sel)), 32'd0);
    check("busy_high", 32'(o_busy(sel)), 32'd1);
  endtask

  task automatic run(input bit sel, input bit stall, input bit poke, input int nbits);
    int    cyc;
    bit    stalled;
    bit    done;
    bit    br;
    logic  sb, ss, se;
    beat_t e;
    cyc = 0; stalled = 0; done = 0;
    while (!done) begin
      if (stalled) begin
        check("stall_bv", 32'(o_bv(sel)), 32'd1);
        check("stall_bit", 32'(o_bit(sel)), 32'(sb));
        check("stall_sof", 32'(o_sof(sel)), 32'(ss));
        check("stall_eof", 32'(o_eof(sel)), 32'(se));
      end
      stalled = 0;
      br = stall ? (cyc % 3 == 0) : 1'b1;
      br_a = br;
      br_b = br;
      if (!o_bv(sel)) begin
        check("bv_during_frame", 32'(o_bv(sel)), 32'd1);
        exp_q.delete();
        done = 1;
      end else if (br) begin
        e = exp_q.pop_front();
        check("beat_bit", 32'(o_bit(sel)), 32'(e.b));
        check("beat_sof", 32'(o_sof(sel)), 32'(e.sof));
        check("beat_eof", 32'(o_eof(sel)), 32'(e.eof));
        if (exp_q.size() == 0) done = 1;
      end else begin
        stalled = 1;
        sb = o_bit(sel); ss = o_sof(sel); se = o_eof(sel);
      end
      if (poke) begin
        valid_a = !done && (cyc % 2 == 0);
        data_a  = 8'h5A;
      end
      cyc++;
      if (cyc > 200 && !done) begin
        check("frame_timeout", 32'(cyc), 32'(nbits));
        exp_q.delete();
        done = 1;
      end
      @(negedge clk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    br_a = 1'b1;
    br_b = 1'b1;
    if (!stall) check("frame_cycles", 32'(cyc), 32'(nbits));
    check("ready_after_frame", 32'(o_ready(sel)), 32'd1);
    check("busy_after_frame", 32'(o_busy(sel)), 32'd0);
    check("bv_after_frame", 32'(o_bv(sel)), 32'd0);
    if (sel) exp_fb = (exp_fb + 1) % 16;
    else     exp_fa = (exp_fa + 1) % 65536;
    check("frames", o_frames(sel), 32'(sel ? exp_fb : exp_fa));
  endtask

  task automatic check_reset_vals(input bit sel);
    check("rst_ready", 32'(o_ready(sel)), 32'd1);
    check("rst_bv", 32'(o_bv(sel)), 32'd0);
    check("rst_bit", 32'(o_bit(sel)), 32'd0);
    check("rst_sof", 32'(o_sof(sel)), 32'd0);
    check("rst_eof", 32'(o_eof(sel)), 32'd0);
    check("rst_busy", 32'(o_busy(sel)), 32'd0);
    check("rst_frames", o_frames(sel), 32'd0);
  endtask

  initial begin
    beat_t e;
    logic [31:0] d;
    bit odd;
    reset = 1'b1;
    data_a = '0; odd_a = 1'b0; valid_a = 1'b0; br_a = 1'b1;
    data_b = '0; odd_b = 1'b0; valid_b = 1'b0; br_b = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b0;

    // Even and odd frames of 8'hB4 at full rate
    send(0, 32'hB4, 1'b0);
    run(0, 1'b0, 1'b0, 16);
    send(0, 32'hB4, 1'b1);
    run(0, 1'b0, 1'b0, 15);

    // Backpressure with upstream pokes while busy
    send(0, 32'hB4, 1'b0);
    run(0, 1'b1, 1'b1, 16);

    // Reset while presenting beat 5
    send(0, 32'hB4, 1'b0);
    br_a = 1'b1;
    repeat (4) begin
      e = exp_q.pop_front();
      check("pre_reset_bit", 32'(bit_a), 32'(e.b));
      @(negedge clk);
    end
    check("beat5_bit", 32'(bit_a), 32'(exp_q[0].b));
    reset = 1'b1;
    #1;
    check_reset_vals(0);
    exp_q.delete();
    exp_fa = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("no_resume_bv", 32'(bv_a), 32'd0);
    send(0, 32'hFF, 1'b0);
    run(0, 1'b0, 1'b0, 16);

    // Shortest frames on W=2, then drive the 4-bit counter through wrap
    send(1, 32'h2, 1'b1);
    run(1, 1'b0, 1'b0, 3);
    send(1, 32'h0, 1'b1);
    run(1, 1'b0, 1'b0, 3);
    send(1, 32'h3, 1'b1);
    run(1, 1'b0, 1'b0, 3);
    for (int k = 0; k < 14; k++) begin
      d   = 32'($urandom_range(0, 3));
      odd = 1'($urandom_range(0, 1));
      send(1, d, odd);
      run(1, 1'b0, 1'b0, odd ? 3 : 4);
    end
    check("frames_wrap", 32'(frames_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
